// File: rtl/sys_matmul_stream.sv
// Streaming N x N matrix multiplier: accepts (a,b) beats column/row-wise, builds C as a
// sum of outer products, then streams C out row-major with optional accumulate across jobs.
module sys_matmul_stream #(
  parameter int N      = 3,
  parameter int DW     = 8,
  parameter int ACC_W  = 2*DW + $clog2(N),
  parameter int SIGNED = 0
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             vld_in,
  output logic             rdy_in,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic             keep,
  output logic             vld_out,
  input  logic             rdy_out,
  output logic [ACC_W-1:0] c,
  output logic             last_out,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
  // the sender holds its data stable until that edge.

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N-1);
  localparam logic [IW-1:0] I_ONE  = IW'(1);

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_MAC = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IW-1:0]    r_i;
  logic [IW-1:0]    r_j;
  logic [IW-1:0]    r_row;
  logic [IW-1:0]    r_col;
  logic             r_keep;
  logic             r_busy;
  logic [DW-1:0]    r_col_buf [N];
  logic [DW-1:0]    r_row_buf [N];
  logic [ACC_W-1:0] r_c [N][N];

  logic w_in_hs;
  logic w_out_hs;
  logic w_last;
  logic w_clear;

  function automatic logic [ACC_W-1:0] ext(input logic [DW-1:0] x);
    if (SIGNED != 0) return {{(ACC_W-DW){x[DW-1]}}, x};
    else             return {{(ACC_W-DW){1'b0}}, x};
  endfunction

  assign rdy_in    = (r_state == S_LOAD);
  assign vld_out   = (r_state == S_DRAIN);
  assign w_last    = (r_row == I_LAST) && (r_col == I_LAST);
  assign last_out  = vld_out && w_last;
  assign c         = vld_out ? r_c[r_row][r_col] : '0;
  assign busy      = r_busy;
  assign dbg_state = r_state;
  assign w_in_hs   = vld_in && rdy_in;
  assign w_out_hs  = vld_out && rdy_out;
  // The first outer product of a non-chained job overwrites whatever C holds.
  assign w_clear   = (r_j == '0) && !r_keep;

  always_ff @(posedge CLK) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:  if (w_in_hs && (r_i == I_LAST)) w_next = S_MAC;
      S_MAC:   w_next = (r_j == I_LAST) ? S_DRAIN : S_LOAD;
      S_DRAIN: if (w_out_hs && w_last) w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_i    <= '0;
      r_j    <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_keep <= 1'b0;
      r_busy <= 1'b0;
      for (int r = 0; r < N; r++) begin
        r_col_buf[r] <= '0;
        r_row_buf[r] <= '0;
        for (int s = 0; s < N; s++) r_c[r][s] <= '0;
      end
    end else begin
      if (w_in_hs) begin
        r_col_buf[r_i] <= a;
        r_row_buf[r_i] <= b;
        r_i            <= (r_i == I_LAST) ? '0 : r_i + I_ONE;
        r_busy         <= 1'b1;
        if ((r_i == '0) && (r_j == '0)) r_keep <= keep;
      end
      if (r_state == S_MAC) begin
        for (int r = 0; r < N; r++)
          for (int s = 0; s < N; s++)
            r_c[r][s] <= (w_clear ? '0 : r_c[r][s]) + ext(r_col_buf[r]) * ext(r_row_buf[s]);
        r_j <= (r_j == I_LAST) ? '0 : r_j + I_ONE;
      end
      if (w_out_hs) begin
        if (r_col == I_LAST) begin
          r_col <= '0;
          r_row <= (r_row == I_LAST) ? '0 : r_row + I_ONE;
        end else begin
          r_col <= r_col + I_ONE;
        end
        if (w_last) r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sys_matmul_stream.sv
// Bench for sys_matmul_stream: an unsigned and a signed instance share all inputs;
// a matrix-level model predicts every output element, checked on each output handshake.
module tb_sys_matmul_stream;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 2*DW + $clog2(N);

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          rst_n, vld_in, keep, rdy_out;
  logic [DW-1:0] a, b;
  logic          rdy_in_u, vld_out_u, last_u, busy_u;
  logic          rdy_in_s, vld_out_s, last_s, busy_s;
  logic [AW-1:0] c_u, c_s;
  logic [1:0]    st_u, st_s;

  sys_matmul_stream #(.N(N), .DW(DW), .SIGNED(0)) u_dut_u (
    .CLK(CLK), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in_u), .a(a), .b(b),
    .keep(keep), .vld_out(vld_out_u), .rdy_out(rdy_out), .c(c_u), .last_out(last_u),
    .busy(busy_u), .dbg_state(st_u));

  sys_matmul_stream #(.N(N), .DW(DW), .SIGNED(1)) u_dut_s (
    .CLK(CLK), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in_s), .a(a), .b(b),
    .keep(keep), .vld_out(vld_out_s), .rdy_out(rdy_out), .c(c_s), .last_out(last_s),
    .busy(busy_s), .dbg_state(st_s));

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_s_q[$];
  logic          exp_last_q[$];
  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];
  logic [AW-1:0] mc_u [N][N];
  logic [AW-1:0] mc_s [N][N];
  bit            toggle_rdy = 1'b0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Matrix-level model: C = A*B (or C + A*B when chained), modulo 2^AW.
  task automatic model_job(input bit k);
    logic [AW-1:0]        sum_u, sum_s;
    logic signed [AW-1:0] xa, xb;
    for (int r = 0; r < N; r++)
      for (int s = 0; s < N; s++) begin
        sum_u = '0;
        sum_s = '0;
        for (int j = 0; j < N; j++) begin
          sum_u = sum_u + AW'(ma[r][j]) * AW'(mb[j][s]);
          xa    = $signed(ma[r][j]);
          xb    = $signed(mb[j][s]);
          sum_s = sum_s + AW'(xa * xb);
        end
        mc_u[r][s] = k ? mc_u[r][s] + sum_u : sum_u;
        mc_s[r][s] = k ? mc_s[r][s] + sum_s : sum_s;
        exp_q.push_back(mc_u[r][s]);
        exp_s_q.push_back(mc_s[r][s]);
        exp_last_q.push_back((r == N-1) && (s == N-1));
      end
  endtask

  task automatic pin_model(input string name, input logic [AW-1:0] lu [9], input logic [AW-1:0] ls [9]);
    int base;
    base = exp_q.size() - 9;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("%s_model_u[%0d]", name, k), exp_q[base+k], lu[k]);
      check($sformatf("%s_model_s[%0d]", name, k), exp_s_q[base+k], ls[k]);
    end
  endtask

  task automatic set_ident();
    for (int r = 0; r < N; r++)
      for (int s = 0; s < N; s++) begin
        ma[r][s] = (r == s) ? 8'd1 : 8'd0;
        mb[r][s] = (r == s) ? 8'd1 : 8'd0;
      end
  endtask

  task automatic set_mats2();
    ma = '{'{8'd1, 8'd1, 8'd0}, '{8'd0, 8'd1, 8'd0}, '{8'd0, 8'd1, 8'd1}};
    mb = '{'{8'd1, 8'd0, 8'd0}, '{8'd0, 8'd2, 8'd0}, '{8'd2, 8'd0, 8'd1}};
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic kv);
    int guard;
    vld_in = 1'b1;
    a      = av;
    b      = bv;
    keep   = kv;
    guard  = 0;
    forever begin
      @(negedge CLK);
      if (rdy_in_u) break;
      guard++;
      if (guard > 400) begin
        failures++;
        $display("FAIL rdy_in_timeout actual=0 required=1");
        $fatal(1, "rdy_in never rose");
      end
    end
    @(posedge CLK);
    #1;
    vld_in = 1'b0;
    a      = $urandom_range(0, 255);
    b      = $urandom_range(0, 255);
    keep   = $urandom_range(0, 1);
  endtask

  task automatic send_job(input bit k, input int max_gap, input bit lat_chk);
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++) begin
        if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin @(posedge CLK); #1; end
        drive_beat(ma[i][j], mb[j][i], (i == 0 && j == 0) ? k : 1'($urandom_range(0, 1)));
        if (i == 0 && j == 0) check("busy_after_first_beat", AW'(busy_u & busy_s), AW'(1));
      end
    if (lat_chk) begin
      @(negedge CLK);
      check("vld_out_low_during_mac", AW'(vld_out_u), AW'(0));
      @(posedge CLK);
      #1;
      check("vld_out_high_t_plus_2", AW'(vld_out_u), AW'(1));
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      @(posedge CLK);
      #2;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain_timeout actual=%0d required=0 pending", name, exp_q.size());
      exp_q.delete();
      exp_s_q.delete();
      exp_last_q.delete();
    end
    check({name, "_busy_clear"}, AW'(busy_u | busy_s), AW'(0));
    check({name, "_vld_out_clear"}, AW'(vld_out_u), AW'(0));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_s_q.delete();
    exp_last_q.delete();
    for (int r = 0; r < N; r++)
      for (int s = 0; s < N; s++) begin
        mc_u[r][s] = '0;
        mc_s[r][s] = '0;
      end
  endtask

  // ---------------- downstream ready ----------------
  initial begin
    rdy_out = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      rdy_out = toggle_rdy ? ~rdy_out : 1'b1;
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic          prev_stall;
    logic [AW-1:0] prev_c;
    prev_stall = 1'b0;
    prev_c     = '0;
    forever begin
      @(negedge CLK);
      if (prev_stall && rst_n) begin
        check("hold_vld_out", AW'(vld_out_u), AW'(1));
        check("hold_c", c_u, prev_c);
      end
      if ((vld_out_u || vld_out_s) && rdy_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h required=none", c_u);
        end else begin
          check("c_unsigned", c_u, exp_q.pop_front());
          check("c_signed", c_s, exp_s_q.pop_front());
          check("vld_out_signed", AW'(vld_out_s), AW'(1));
          check("last_out", AW'({last_s, last_u}), AW'({2{exp_last_q.pop_front()}}));
        end
      end
      prev_stall = vld_out_u && !rdy_out;
      prev_c     = c_u;
    end
  end

  // ---------------- directed scenarios ----------------
  localparam logic [AW-1:0] I_PAT [9]  = '{18'd1, 18'd0, 18'd0, 18'd0, 18'd1, 18'd0, 18'd0, 18'd0, 18'd1};
  localparam logic [AW-1:0] I2_PAT [9] = '{18'd2, 18'd0, 18'd0, 18'd0, 18'd2, 18'd0, 18'd0, 18'd0, 18'd2};
  localparam logic [AW-1:0] M2_PAT [9] = '{18'd1, 18'd2, 18'd0, 18'd0, 18'd2, 18'd0, 18'd2, 18'd2, 18'd1};
  localparam logic [AW-1:0] U3_PAT [9] = '{9{18'h005FA}};
  localparam logic [AW-1:0] S3_PAT [9] = '{9{18'h3FFFA}};

  initial begin
    rst_n  = 1'b0;
    vld_in = 1'b0;
    a      = '0;
    b      = '0;
    keep   = 1'b0;
    for (int r = 0; r < N; r++)
      for (int s = 0; s < N; s++) begin
        mc_u[r][s] = '0;
        mc_s[r][s] = '0;
      end
    repeat (2) @(posedge CLK);
    #1;
    check("reset_rdy_in", AW'(rdy_in_u & rdy_in_s), AW'(1));
    check("reset_vld_out", AW'(vld_out_u | vld_out_s), AW'(0));
    check("reset_last_out", AW'(last_u | last_s), AW'(0));
    check("reset_busy", AW'(busy_u | busy_s), AW'(0));
    check("reset_c", c_u | c_s, AW'(0));
    rst_n = 1'b1;
    @(posedge CLK);
    #1;

    // identity, with latency check
    set_ident();
    model_job(1'b0);
    pin_model("ident", I_PAT, I_PAT);
    send_job(1'b0, 0, 1'b1);
    wait_drain("s1");

    // mixed small matrices
    set_mats2();
    model_job(1'b0);
    pin_model("mats2", M2_PAT, M2_PAT);
    send_job(1'b0, 0, 1'b0);
    wait_drain("s2");

    // all-ones-byte A times 2: unsigned 1530, signed -6
    for (int r = 0; r < N; r++)
      for (int s = 0; s < N; s++) begin
        ma[r][s] = 8'hFF;
        mb[r][s] = 8'd2;
      end
    model_job(1'b0);
    pin_model("ff_by_2", U3_PAT, S3_PAT);
    send_job(1'b0, 0, 1'b0);
    wait_drain("s3");

    // chaining: I, then I + I, then overwrite back to I
    set_ident();
    model_job(1'b0);
    send_job(1'b0, 0, 1'b0);
    wait_drain("s4a");
    model_job(1'b1);
    pin_model("chain", I2_PAT, I2_PAT);
    send_job(1'b1, 0, 1'b0);
    wait_drain("s4b");
    model_job(1'b0);
    pin_model("rechain", I_PAT, I_PAT);
    send_job(1'b0, 0, 1'b0);
    wait_drain("s4c");

    // input gaps plus downstream backpressure
    set_mats2();
    model_job(1'b0);
    pin_model("gaps", M2_PAT, M2_PAT);
    toggle_rdy = 1'b1;
    send_job(1'b0, 3, 1'b0);
    wait_drain("s5");
    toggle_rdy = 1'b0;
    @(posedge CLK);
    #1;

    // abort mid-load, then a chained identity job must see a cleared C
    set_mats2();
    for (int k = 0; k < 5; k++) drive_beat(ma[k % N][k / N], mb[k / N][k % N], 1'b1);
    pulse_reset();
    check("post_reset_busy", AW'(busy_u | busy_s), AW'(0));
    check("post_reset_vld_out", AW'(vld_out_u | vld_out_s), AW'(0));
    check("post_reset_rdy_in", AW'(rdy_in_u), AW'(1));
    set_ident();
    model_job(1'b1);
    pin_model("after_abort", I_PAT, I_PAT);
    send_job(1'b1, 0, 1'b0);
    wait_drain("s6");

    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
